ins_fetch_unit: RTL and testbench

// - Parametrised front end: holds the fetch PC, fetches one instruction at a time from the ICache,

---
 rtl/ins_fetch_unit_pkg.sv | 5 +
 rtl/ins_fetch_unit_ins_queue.sv | 45 ++++
 rtl/ins_fetch_unit.sv | 94 +++++++++
 tb/tb_ins_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_unit_pkg.sv
// ins_fetch_unit_pkg: shared state encoding and constants for the fetch front end
package ins_fetch_unit_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} if_state_e;
  localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/ins_fetch_unit_ins_queue.sv
// ins_fetch_unit_ins_queue: circular instruction FIFO with push/pop/flush and occupancy count
module ins_fetch_unit_ins_queue #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
    count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (rdy) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rdy && do_push) mem_q[wr_ptr_q] <= din;
  end
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: fetch PC + single-outstanding ICache request FSM feeding an instruction queue
module ins_fetch_unit
  import ins_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              INS_W       = 32,
  parameter int              QUEUE_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              icache_req_valid,
  output logic [ADDR_W-1:0] icache_req_addr,
  input  logic              icache_resp_valid,
  input  logic [INS_W-1:0]  icache_resp_ins,
  output logic [ADDR_W-1:0] pred_pc,
  output logic [INS_W-1:0]  pred_ins,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [INS_W-1:0]  issue_ins,
  output logic [ADDR_W-1:0] issue_pc,
  output logic              issue_pred_taken,
  input  logic              rollback,
  input  logic [ADDR_W-1:0] rollback_pc
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int EW = ADDR_W + INS_W + 1;
  if_state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d;
  logic req_valid_q, req_valid_d;
  logic push, pop;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    req_valid_d = req_valid_q;
    push        = 1'b0;
    if (rollback) begin
      fetch_pc_d  = rollback_pc;
      req_valid_d = 1'b0;
      state_d     = (state_q == S_IDLE || icache_resp_valid) ? S_IDLE : S_DROP;
    end else if (state_q == S_IDLE) begin
      if (count < CW'(QUEUE_DEPTH)) begin
        state_d     = S_WAIT;
        req_valid_d = 1'b1;
        req_addr_d  = fetch_pc_q;
      end
    end else if (icache_resp_valid) begin
      state_d     = S_IDLE;
      req_valid_d = 1'b0;
      // a word returned in DROP belongs to the flushed path and is discarded
      if (state_q == S_WAIT) begin
        push       = 1'b1;
        fetch_pc_d = pred_taken ? pred_target : fetch_pc_q + ADDR_W'(PC_STEP);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_valid_q <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      req_valid_q <= req_valid_d;
    end
  end
  assign pop = issue_valid && issue_ready && !rollback;
  ins_fetch_unit_ins_queue #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .push  (push),
    .pop   (pop),
    .flush (rollback),
    .din   ({fetch_pc_q, icache_resp_ins, pred_taken}),
    .dout  (head),
    .count (count)
  );
  assign icache_req_valid = req_valid_q;
  assign icache_req_addr  = req_addr_q;
  assign pred_pc          = req_addr_q;
  assign pred_ins         = icache_resp_ins;
  assign issue_valid      = count != '0;
  assign {issue_pc, issue_ins, issue_pred_taken} = head;
endmodule

// File: tb/tb_ins_fetch_unit.sv
// tb_ins_fetch_unit: directed scenarios with an ICache/predictor model and an issue-order scoreboard
module tb_ins_fetch_unit;
  localparam int LAT = 3;
  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic        icache_req_valid, icache_resp_valid = 1'b0;
  logic [31:0] icache_req_addr, icache_resp_ins = '0;
  logic [31:0] pred_pc, pred_ins, pred_target;
  logic        pred_taken;
  logic        issue_valid, issue_ready = 1'b1, issue_pred_taken;
  logic [31:0] issue_ins, issue_pc;
  logic        rollback = 1'b0;
  logic [31:0] rollback_pc = '0;
  logic        br_en = 1'b0;
  logic [31:0] br_pc = '0, br_tgt = '0;

  typedef struct packed {logic [31:0] pc; logic [31:0] ins; logic tk;} ent_t;
  ent_t sb[$];
  int n_cmp = 0, n_err = 0, n_push = 0, n_req = 0, n_pop = 0, lat = 0;
  logic out_pend = 1'b0, dropped = 1'b0, saw_taken = 1'b0;
  logic [31:0] model_pc = '0, pend_addr = '0;

  always #5 clk = ~clk;
  assign pred_taken  = br_en && (pred_pc == br_pc);
  assign pred_target = br_tgt;

  ins_fetch_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_ins(icache_resp_ins),
    .pred_pc(pred_pc), .pred_ins(pred_ins), .pred_taken(pred_taken), .pred_target(pred_target),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ins(issue_ins),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // settle this cycle's handshakes against the model, then advance to the next negedge
  task automatic tick();
    ent_t e;
    logic tk;
    if (!rst && rdy) begin
      if (issue_valid && issue_ready && !rollback) begin
        if (sb.size() == 0) chk("pop_with_nothing_expected", 64'(issue_valid), 64'(0));
        else begin
          e = sb.pop_front();
          chk("issue_pc", 64'(issue_pc), 64'(e.pc));
          chk("issue_ins", 64'(issue_ins), 64'(e.ins));
          chk("issue_pred_taken", 64'(issue_pred_taken), 64'(e.tk));
          if (e.tk && e.pc == 32'h8) saw_taken = 1'b1;
          n_pop++;
        end
      end
      if (icache_resp_valid && !rollback && !dropped) begin
        tk = br_en && model_pc == br_pc;
        chk("pred_pc", 64'(pred_pc), 64'(model_pc));
        chk("pred_ins", 64'(pred_ins), 64'(icache_resp_ins));
        sb.push_back('{model_pc, icache_resp_ins, tk});
        n_push++;
        model_pc = tk ? br_tgt : model_pc + 32'd4;
      end
      if (icache_resp_valid) begin out_pend = 1'b0; dropped = 1'b0; end
      if (rollback) begin sb.delete(); model_pc = rollback_pc; dropped = out_pend; end
    end
    @(negedge clk);
    icache_resp_valid = 1'b0;
    if (rst) begin
      out_pend = 1'b0; dropped = 1'b0; lat = 0; sb.delete(); model_pc = '0;
    end else if (rdy) begin
      if (icache_req_valid && !out_pend) begin
        out_pend = 1'b1; lat = 0; n_req++; pend_addr = icache_req_addr;
        chk("req_addr", 64'(icache_req_addr), 64'(model_pc));
      end
      if (out_pend) begin
        lat++;
        if (lat == LAT) begin icache_resp_valid = 1'b1; icache_resp_ins = ins_of(pend_addr); end
      end
    end
  endtask

  initial begin
    logic [31:0] a0;
    logic        v0;
    int p0, r0, i;
    repeat (3) tick();
    chk("rst_req_valid", 64'(icache_req_valid), 64'(0));
    chk("rst_issue_valid", 64'(issue_valid), 64'(0));
    rst = 1'b0;
    // sequential fetch, no branches
    repeat (30) tick();
    chk("seq_pops", 64'(n_pop >= 5), 64'(1));
    // taken branch at 0x8 redirects to 0x100
    br_en = 1'b1; br_pc = 32'h8; br_tgt = 32'h100;
    rollback = 1'b1; rollback_pc = 32'h0; tick(); rollback = 1'b0;
    repeat (40) tick();
    chk("branch_entry_seen", 64'(saw_taken), 64'(1));
    chk("after_branch_pc", 64'(model_pc > 32'h100), 64'(1));
    br_en = 1'b0;
    // fill queue with issue stalled
    issue_ready = 1'b0;
    repeat (80) tick();
    chk("full_entries", 64'(sb.size()), 64'(8));
    chk("full_req_valid", 64'(icache_req_valid), 64'(0));
    chk("full_issue_valid", 64'(issue_valid), 64'(1));
    r0 = n_req;
    repeat (10) tick();
    chk("full_no_new_req", 64'(n_req), 64'(r0));
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    r0 = n_req;
    repeat (20) tick();
    chk("refill_one_req", 64'(n_req), 64'(r0 + 1));
    chk("refill_entries", 64'(sb.size()), 64'(8));
    // rollback while a request is outstanding
    issue_ready = 1'b1;
    repeat (20) tick();
    for (i = 0; i < 50 && !(out_pend && lat == 1); i++) tick();
    chk("found_wait_a", 64'(out_pend && lat == 1), 64'(1));
    rollback = 1'b1; rollback_pc = 32'h200; tick(); rollback = 1'b0;
    chk("rb_wait_empty", 64'(issue_valid), 64'(0));
    chk("rb_wait_req_low", 64'(icache_req_valid), 64'(0));
    p0 = n_push;
    repeat (25) tick();
    chk("rb_wait_refetch", 64'(n_push > p0), 64'(1));
    // rollback coinciding with a response and a pop
    issue_ready = 1'b0;
    p0 = n_push;
    for (i = 0; i < 60 && n_push < p0 + 2; i++) tick();
    for (i = 0; i < 20 && !icache_resp_valid; i++) tick();
    chk("found_resp", 64'(icache_resp_valid), 64'(1));
    issue_ready = 1'b1; rollback = 1'b1; rollback_pc = 32'h300;
    chk("rb_resp_queue_busy", 64'(issue_valid), 64'(1));
    p0 = n_pop;
    tick(); rollback = 1'b0;
    chk("rb_resp_empty", 64'(issue_valid), 64'(0));
    chk("rb_resp_no_pop", 64'(n_pop), 64'(p0));
    repeat (25) tick();
    chk("rb_resp_refetch", 64'(n_pop > p0), 64'(1));
    // freeze mid-request, then asynchronous reset
    for (i = 0; i < 50 && !(out_pend && lat == 1); i++) tick();
    chk("found_wait_b", 64'(out_pend && lat == 1), 64'(1));
    rdy = 1'b0;
    a0 = icache_req_addr; v0 = icache_req_valid;
    repeat (5) begin
      tick();
      chk("frz_req_valid", 64'(icache_req_valid), 64'(v0));
      chk("frz_req_addr", 64'(icache_req_addr), 64'(a0));
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_req_valid", 64'(icache_req_valid), 64'(0));
    chk("arst_req_addr", 64'(icache_req_addr), 64'(0));
    chk("arst_issue_valid", 64'(issue_valid), 64'(0));
    tick(); tick();
    rdy = 1'b1; rst = 1'b0;
    p0 = n_pop;
    repeat (30) tick();
    chk("post_reset_pops", 64'(n_pop >= p0 + 4), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
